// File: rtl/tsp16_pkg.sv
// Shared TSP16 types and constants used by fetch and decode.
package tsp16_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam word_t      RESET_PC_DEF    = 16'h0000;
  localparam int         LONG_BIT_DEF    = 11;
  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;

  // Major opcode lives in the top nibble of word0.
  function automatic logic [3:0] opcode(input word_t w);
    return w[15:12];
  endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational word0 classifier: instruction length and HALT detection.
module instr_len_decode
  import tsp16_pkg::*;
#(
  parameter int         LONG_BIT    = LONG_BIT_DEF,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic [15:0] word0,
  output logic        len,
  output logic        is_halt
);

  // Length flag and opcode compare are pure functions of word0.
  always_comb begin
    len     = word0[LONG_BIT];
    is_halt = (opcode(word0) == HALT_OPCODE);
  end

endmodule

// File: rtl/fetch_unit.sv
// TSP16 instruction-fetch initiator: drives pc/next_pc, registers one
// instruction per decode handshake, follows redirects and stops on HALT.
//
//  state | meaning
//  IDLE  | after reset, waiting for start; no loads
//  FETCH | loading instructions whenever the output register can take one
//  HALT  | HALT instruction loaded; waits for redirect or reset
module fetch_unit
  import tsp16_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEF,
  parameter int          LONG_BIT    = LONG_BIT_DEF,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] pc,
  output logic [15:0] next_pc,
  input  logic [15:0] fetch_instr,
  input  logic [15:0] fetch_next_instr,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word0,
  output logic [15:0] out_word1,
  output logic        out_len,
  output logic [15:0] out_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_FETCH = 2'(FETCH);
  localparam logic [1:0] ST_HALT  = 2'(HALT);

  logic [1:0]  state;
  logic [15:0] pc_q;
  logic        dec_len;
  logic        dec_halt;
  logic        xfer;
  logic        load;

  instr_len_decode #(
    .LONG_BIT   (LONG_BIT),
    .HALT_OPCODE(HALT_OPCODE)
  ) u_len_decode (
    .word0  (fetch_instr),
    .len    (dec_len),
    .is_halt(dec_halt)
  );

  // Memory read addresses come straight from the PC register.
  always_comb begin
    pc      = pc_q;
    next_pc = pc_q + 16'd1;
    halted  = (state == ST_HALT);
  end

  // Handshake and load qualification; redirect always wins over a load.
  always_comb begin
    xfer = out_valid && out_ready;
    load = (state == ST_FETCH) && !redirect_valid && (!out_valid || out_ready);
  end

  // PC, FSM, instruction register and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_word0   <= 16'h0000;
      out_word1   <= 16'h0000;
      out_len     <= 1'b0;
      out_pc      <= 16'h0000;
      fetch_count <= 16'h0000;
    end else begin
      if (xfer) begin
        fetch_count <= fetch_count + 16'd1;
      end

      if (redirect_valid) begin
        // Squash whatever is pending and restart fetching at the target.
        pc_q      <= redirect_pc;
        out_valid <= 1'b0;
        state     <= ST_FETCH;
      end else if (load) begin
        out_valid <= 1'b1;
        out_word0 <= fetch_instr;
        out_pc    <= pc_q;
        out_len   <= dec_len;
        out_word1 <= dec_len ? fetch_next_instr : 16'h0000;
        pc_q      <= pc_q + 16'd1 + {15'd0, dec_len};
        if (dec_halt) begin
          state <= ST_HALT;
        end
      end else if (xfer) begin
        out_valid <= 1'b0;
      end else if ((state == ST_IDLE) && start) begin
        state <= ST_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a memory-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pc, next_pc;
  logic [15:0] fetch_instr, fetch_next_instr;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_word0, out_word1, out_pc, fetch_count;
  logic        out_len, halted;

  logic [15:0] mem [0:65535];

  int  nchecks = 0;
  int  nerrors = 0;
  bit  chk_en  = 1'b0;

  always #5 clk = ~clk;

  assign fetch_instr      = mem[pc];
  assign fetch_next_instr = mem[next_pc];

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pc              (pc),
    .next_pc         (next_pc),
    .fetch_instr     (fetch_instr),
    .fetch_next_instr(fetch_next_instr),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_word0       (out_word0),
    .out_word1       (out_word1),
    .out_len         (out_len),
    .out_pc          (out_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting for start, 1 = running, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc, m_word0, m_word1, m_opc, m_count;
  logic        m_valid, m_len;

  always @(posedge clk) begin
    logic [15:0] w;
    if (reset) begin
      m_mode = 0; m_pc = 16'h0000; m_valid = 0; m_word0 = 0; m_word1 = 0;
      m_len = 0; m_opc = 0; m_count = 0;
    end else begin
      if (m_valid && out_ready) m_count = m_count + 16'd1;
      if (redirect_valid) begin
        m_pc = redirect_pc; m_valid = 0; m_mode = 1;
      end else if (m_mode == 1 && (!m_valid || out_ready)) begin
        w       = mem[m_pc];
        m_word0 = w;
        m_opc   = m_pc;
        m_len   = w[11];
        m_word1 = m_len ? mem[16'(m_pc + 16'd1)] : 16'h0000;
        m_valid = 1;
        m_pc    = m_pc + (m_len ? 16'd2 : 16'd1);
        if (w[15:12] == 4'hF) m_mode = 2;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end else if (m_mode == 0 && start) begin
        m_mode = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("next_pc", next_pc, 16'(m_pc + 16'd1));
      chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
      chk("halted", {15'd0, halted}, {15'd0, m_mode == 2});
      chk("fetch_count", fetch_count, m_count);
      if (m_valid) begin
        chk("out_word0", out_word0, m_word0);
        chk("out_word1", out_word1, m_word1);
        chk("out_len", {15'd0, out_len}, {15'd0, m_len});
        chk("out_pc", out_pc, m_opc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redirect_to(input logic [15:0] a);
    redirect_valid = 1'b1; redirect_pc = a;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1000; mem[1] = 16'h2800; mem[2] = 16'hABCD; mem[3] = 16'hF000;
    mem[16'h0040] = 16'h3000; mem[16'h0041] = 16'hF000;

    step(2);
    chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_count", fetch_count, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    step(2);
    chk("idle_no_load", {15'd0, out_valid}, 16'd0);

    // Straight line to HALT.
    start = 1'b1; out_ready = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    chk("sl_halted", {15'd0, halted}, 16'd1);
    chk("sl_count", fetch_count, 16'd3);
    chk("sl_pc", pc, 16'h0004);
    step(2);
    chk("sl_hold_pc", pc, 16'h0004);

    // Backpressure after the first load.
    redirect_to(16'h0000);
    step(1);
    out_ready = 1'b0;
    step(3);
    chk("bp_pc", pc, 16'h0001);
    chk("bp_outpc", out_pc, 16'h0000);
    chk("bp_word0", out_word0, 16'h1000);
    chk("bp_count", fetch_count, 16'd3);
    out_ready = 1'b1;
    step(3);
    chk("bp_resume_count", fetch_count, 16'd6);
    chk("bp_resume_halt", {15'd0, halted}, 16'd1);

    // Redirect while stalled.
    redirect_to(16'h0000);
    out_ready = 1'b0;
    step(1);
    chk("rs_stalled", {15'd0, out_valid}, 16'd1);
    redirect_to(16'h0040);
    chk("rs_squash", {15'd0, out_valid}, 16'd0);
    chk("rs_pc", pc, 16'h0040);
    step(1);
    chk("rs_outpc", out_pc, 16'h0040);
    chk("rs_count", fetch_count, 16'd6);
    out_ready = 1'b1;
    step(3);
    chk("rs_count2", fetch_count, 16'd8);

    // PC wrap with a long instruction at 0xFFFF.
    mem[16'hFFFF] = 16'h0800; mem[0] = 16'h1234;
    redirect_to(16'hFFFF);
    chk("wr_pc", pc, 16'hFFFF);
    chk("wr_next_pc", next_pc, 16'h0000);
    step(1);
    chk("wr_word1", out_word1, 16'h1234);
    chk("wr_len", {15'd0, out_len}, 16'd1);
    chk("wr_newpc", pc, 16'h0001);
    step(4);

    // Halt exit, redirect with concurrent transfer, then reset mid-stream.
    redirect_to(16'h0010);
    chk("hx_halted", {15'd0, halted}, 16'd0);
    step(3);
    redirect_to(16'h0020);
    step(2);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0077; start = 1'b1;
    step(1);
    chk("mr_valid", {15'd0, out_valid}, 16'd0);
    chk("mr_pc", pc, 16'h0000);
    chk("mr_count", fetch_count, 16'd0);
    chk("mr_word0", out_word0, 16'h0000);
    chk("mr_outpc", out_pc, 16'h0000);
    reset = 1'b0; redirect_valid = 1'b0; start = 1'b0;
    step(3);
    chk("mr_idle", {15'd0, out_valid}, 16'd0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    chk("mr_restart", out_word0, 16'h1234);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
